systolic_feeder: RTL

- Controller and operand feeder for the 3x3 output-stationary systolic multiplier array.
- Accepts two 3x3 operand matrices A and B through a start/busy handshake.
- Clears the array, then drives the skewed row/column streams a1..a3 and b1..b3 into it.
- Waits for the pipeline to drain, then captures c1..c9 into a held result register and pulses done.

---
 rtl/systolic_feeder.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/systolic_feeder.sv
// Operand feeder and sequencer for a 3x3 output-stationary systolic multiplier.
// Latches A/B on start, clears the array, streams skewed rows/columns, drains, then captures C.
module systolic_feeder #(
  parameter int DATA_SIZE    = 8,
  parameter int FLUSH_CYCLES = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [9*DATA_SIZE-1:0]         a_mat,
  input  logic [9*DATA_SIZE-1:0]         b_mat,
  output logic                           busy,
  output logic                           arr_clr,
  output logic [DATA_SIZE-1:0]           a1,
  output logic [DATA_SIZE-1:0]           a2,
  output logic [DATA_SIZE-1:0]           a3,
  output logic [DATA_SIZE-1:0]           b1,
  output logic [DATA_SIZE-1:0]           b2,
  output logic [DATA_SIZE-1:0]           b3,
  input  logic [9*(2*DATA_SIZE+1)-1:0]   c_in,
  output logic [9*(2*DATA_SIZE+1)-1:0]   result,
  output logic                           result_valid,
  output logic                           done
);

  // state   | meaning
  // IDLE    | waiting for start; result held
  // CLEAR   | arr_clr asserted for one cycle
  // STREAM  | seven skewed feed beats (beat 0..6)
  // FLUSH   | feeds zero while the array drains
  // CAPTURE | c_in sampled into result, done pulsed
  typedef enum logic [2:0] {IDLE, CLEAR, STREAM, FLUSH, CAPTURE} state_t;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  state_t                        state, state_nx;
  logic [2:0]                    beat, beat_nx;
  logic [3:0]                    fcnt, fcnt_nx;
  logic [9*DATA_SIZE-1:0]        a_reg, b_reg;
  logic [2:0][DATA_SIZE-1:0]     a_feed, b_feed, a_feed_nx, b_feed_nx;
  logic                          busy_nx, clr_nx, done_nx, load, capture;

  function automatic logic [2:0][DATA_SIZE-1:0] row_feed(input logic [9*DATA_SIZE-1:0] m,
                                                          input logic [2:0] t);
    logic [2:0][DATA_SIZE-1:0] f;
    int d;
    f = '0;
    for (int r = 0; r < 3; r++) begin
      d = int'(t) - r;
      if (d >= 0 && d <= 2) f[r] = m[DATA_SIZE*(3*r+d) +: DATA_SIZE];
    end
    return f;
  endfunction

  function automatic logic [2:0][DATA_SIZE-1:0] col_feed(input logic [9*DATA_SIZE-1:0] m,
                                                          input logic [2:0] t);
    logic [2:0][DATA_SIZE-1:0] f;
    int d;
    f = '0;
    for (int c = 0; c < 3; c++) begin
      d = int'(t) - c;
      if (d >= 0 && d <= 2) f[c] = m[DATA_SIZE*(3*d+c) +: DATA_SIZE];
    end
    return f;
  endfunction

  always_comb begin
    state_nx  = state;
    beat_nx   = beat;
    fcnt_nx   = fcnt;
    busy_nx   = busy;
    clr_nx    = 1'b0;
    done_nx   = 1'b0;
    load      = 1'b0;
    capture   = 1'b0;
    a_feed_nx = '0;
    b_feed_nx = '0;
    case (state)
      IDLE: begin
        if (start) begin
          load     = 1'b1;
          busy_nx  = 1'b1;
          clr_nx   = 1'b1;
          state_nx = CLEAR;
        end
      end
      CLEAR: begin
        state_nx  = STREAM;
        beat_nx   = 3'd0;
        a_feed_nx = row_feed(a_reg, 3'd0);
        b_feed_nx = col_feed(b_reg, 3'd0);
      end
      STREAM: begin
        if (beat == 3'd6) begin
          state_nx = FLUSH;
          fcnt_nx  = FLUSH_LOAD;
        end else begin
          beat_nx   = beat + 3'd1;
          a_feed_nx = row_feed(a_reg, beat + 3'd1);
          b_feed_nx = col_feed(b_reg, beat + 3'd1);
        end
      end
      FLUSH: begin
        if (fcnt == 4'd0) state_nx = CAPTURE;
        else              fcnt_nx  = fcnt - 4'd1;
      end
      CAPTURE: begin
        capture  = 1'b1;
        done_nx  = 1'b1;
        busy_nx  = 1'b0;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      beat         <= '0;
      fcnt         <= '0;
      a_reg        <= '0;
      b_reg        <= '0;
      a_feed       <= '0;
      b_feed       <= '0;
      busy         <= 1'b0;
      arr_clr      <= 1'b0;
      done         <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      state   <= state_nx;
      beat    <= beat_nx;
      fcnt    <= fcnt_nx;
      a_feed  <= a_feed_nx;
      b_feed  <= b_feed_nx;
      busy    <= busy_nx;
      arr_clr <= clr_nx;
      done    <= done_nx;
      if (load) begin
        a_reg        <= a_mat;
        b_reg        <= b_mat;
        result_valid <= 1'b0;
      end
      if (capture) begin
        result       <= c_in;
        result_valid <= 1'b1;
      end
    end
  end

  assign a1 = a_feed[0];
  assign a2 = a_feed[1];
  assign a3 = a_feed[2];
  assign b1 = b_feed[0];
  assign b2 = b_feed[1];
  assign b3 = b_feed[2];

endmodule
